adam_mioc: RTL and testbench
============================

// Module: adam_mioc
// PURPOSE
// - Memory/IO controller for the ADAM Z80 board. Decodes the buffered Z80 bus into DRAM
//   strobes (RAS/CAS/MUX), ROM and expansion selects, and bus-buffer enables.
// - Holds the memory-map and control registers, and distributes resets.
// - Handles the DMA bus request. Sits between the buffered CPU bus and the DRAM, ROM and
//   expansion devices.
// PARAMETERS
// - none
// PORTS
// B_PHI        in  1  system clock (CPU phi); all registers use the rising edge
// N_CVRST      in  1  asynchronous, active-high reset (1 = clear all registers)
// PBRST_N      in  1  pushbutton reset, active low
// BA15,BA14,BA13,BA7,BA6  in 1 each  buffered address bits
// BD0..BD3     in  1 each  buffered data bits 0..3
// N_BWR,BRD_N  in  1  buffered write / read strobes, active low
// BMREQ_N,IORQ_N,BRFSH_N,BM1_N  in 1  buffered Z80 MREQ/IORQ/RFSH/M1, active low
// WAIT_N       in  1  bus wait, active low
// BUSAK_N      in  1  Z80 bus acknowledge, active low
// DMA_N        in  1  DMA request from peripheral, active low
// OS3_N        in  1  external port-group-3 select, active low
// RA7          out 1  DRAM row address bit 7
// RAS_N,CAS1_N,CAS2_N,MUX  out 1  DRAM strobes: CAS1 = lower 32K bank, CAS2 = upper bank
// BOOTROMCS_N,AUXROMCS_N,AUXDECODE1_N  out 1  boot ROM / OS7 ROM / expansion selects
// ADDRBUFEN_N,EN245_N  out 1  address buffer / data transceiver enables
// BUSRQ_N      out 1  Z80 bus request
// RST_N,CPRST_N,NETRST_N  out 1  system / coprocessor / network resets
// SPINDIS_N    out 1  spinner disable
// IS3_N        out 1  qualified port-3 read select
// BEHAVIOUR
// - Definitions:
//   - mcyc = ~BMREQ_N & BRFSH_N
//   - rcyc = ~BMREQ_N & ~BRFSH_N
//   - iow  = ~IORQ_N & BM1_N & ~N_BWR
// - MAP register (4b):
//   - Loaded from BD3..BD0 on the rising edge when iow & BA7=0 & BA6=1 (port 0x7F).
//   - lo = MAP[1:0]: 00 boot ROM, 01 internal RAM, 10 expansion RAM, 11 OS7 (0x0000-1FFF)
//     plus internal RAM above it.
//   - hi = MAP[3:2]: 00 internal RAM, 01 expansion RAM, 10 expansion ROM, 11 cartridge.
// - CTRL register (3b):
//   - Loaded from BD2..BD0 when iow & BA7=0 & BA6=0 (port 0x3F).
//   - Bit0 = net reset, bit1 = spinner disable, bit2 = coprocessor reset.
// - N_CVRST=1 (async): MAP=0000, CTRL=000, BUSRQ flop=1, refresh counter=0, MUX flop=0.
// - PBRST_N=0 synchronously clears MAP and CTRL on each rising edge.
// - Resets:
//   - RST_N    = ~(N_CVRST | ~PBRST_N)
//   - NETRST_N = RST_N & ~CTRL[0]
//   - CPRST_N  = RST_N & ~CTRL[2]
//   - SPINDIS_N = ~CTRL[1]
// - Region decode (combinational, lower half = ~BA15):
//   - BOOTROMCS_N low: mcyc & ~BA15 & lo=00.
//   - AUXROMCS_N low: mcyc & ~BA15 & lo=11 & BA14=0 & BA13=0.
//   - AUXDECODE1_N low: mcyc & ((~BA15 & lo=10) | (BA15 & hi!=00)).
//   - int_lo (internal RAM, lower half): mcyc & ~BA15 & (lo=01 | (lo=11 & (BA14|BA13))).
//   - int_hi (internal RAM, upper half): mcyc & BA15 & hi=00.
// - DRAM:
//   - RAS_N = BMREQ_N (combinational; asserted for both memory and refresh cycles).
//   - MUX flop: set on the first rising edge with mcyc=1; cleared on the first edge with
//     BMREQ_N=1. One-clock latency.
//   - CAS1_N = ~(MUX & int_lo & (~BRD_N | ~N_BWR)); CAS2_N likewise with int_hi.
//   - Refresh cycles never assert CAS and never set MUX.
//   - CAS stays asserted while WAIT_N=0 and BMREQ_N stays low.
// - RA7:
//   - 8-bit refresh counter increments on each rising edge where BRFSH_N was 0 on the
//     previous edge and is 1 now; wraps 255->0.
//   - RA7 = ~BRFSH_N ? cnt[7] : BA7.
// - BUSRQ_N:
//   - Registered; goes 0 on the first rising edge with DMA_N=0 & WAIT_N=1.
//   - Returns to 1 on the first edge with DMA_N=1.
// - Buffers:
//   - ADDRBUFEN_N = ~BUSAK_N (address buffers disabled while DMA master owns the bus).
//   - EN245_N = ~(BUSAK_N & (mcyc | (~IORQ_N & BM1_N))).
//   - IS3_N = OS3_N | BRD_N.
// - Simultaneous events:
//   - Reset beats a register write.
//   - During an interrupt acknowledge (BM1_N=0 & IORQ_N=0) there is no register write.
// TESTING
// 1. Reset: N_CVRST=1 -> RST_N=0, SPINDIS_N=1, BUSRQ_N=1, MUX=0, MAP=0. Then N_CVRST=0 &
//    PBRST_N=1 -> RST_N=1; BMREQ_N=0, BA15=0 -> BOOTROMCS_N=0.
// 2. Write 0x1 to port 0x7F (IORQ_N=0, N_BWR=0, BA7=0, BA6=1, BD=0001), then read 0x2000
//    (BMREQ_N=0, BRD_N=0) -> RAS_N=0 at once, MUX=1 after one edge, CAS1_N=0,
//    BOOTROMCS_N=1.
// 3. MAP=0011, read 0x0000 -> AUXROMCS_N=0, CAS1_N=1. Read 0x2000 -> CAS1_N=0. MAP=0100,
//    read 0x8000 -> AUXDECODE1_N=0, CAS2_N=1.
// 4. Refresh: BMREQ_N=0, BRFSH_N=0 -> RAS_N=0, CAS1_N=CAS2_N=1, MUX=0. After 128 refresh
//    pulses RA7=1 during refresh; RA7 follows BA7 otherwise.
// 5. DMA_N=0 -> BUSRQ_N=0 on the next edge. BUSAK_N=0 -> ADDRBUFEN_N=1, EN245_N=1.
//    DMA_N=1 -> BUSRQ_N=1 on the next edge.
// 6. Write CTRL=101 to port 0x3F -> NETRST_N=0, CPRST_N=0. PBRST_N=0 -> RST_N=0, and CTRL
//    reads back 000 after the next edge.

Source files
------------

// File: rtl/adam_mioc.sv
// adam_mioc -- memory/IO controller for the ADAM Z80 board.
//
// Decodes the buffered Z80 bus into DRAM strobes (RAS/CAS/MUX), ROM and
// expansion selects, and bus-buffer enables. Holds the memory-map (MAP) and
// control (CTRL) registers, distributes resets and handles the DMA bus
// request.
//
// Ports
//   B_PHI                      system clock, all flops use the rising edge
//   N_CVRST                    asynchronous active-high reset
//   PBRST_N                    pushbutton reset (synchronously clears MAP/CTRL)
//   BA15,BA14,BA13,BA7,BA6     buffered address bits
//   BD0..BD3                   buffered data bits
//   N_BWR,BRD_N                buffered write/read strobes (active low)
//   BMREQ_N,IORQ_N,BRFSH_N,BM1_N  buffered Z80 cycle strobes (active low)
//   WAIT_N,BUSAK_N,DMA_N,OS3_N bus wait, bus ack, DMA request, port-3 select
//   RA7                        DRAM row address bit 7 (refresh counter MSB)
//   RAS_N,CAS1_N,CAS2_N,MUX    DRAM strobes (CAS1 lower 32K, CAS2 upper 32K)
//   BOOTROMCS_N,AUXROMCS_N,AUXDECODE1_N  ROM / expansion selects
//   ADDRBUFEN_N,EN245_N        address buffer / data transceiver enables
//   BUSRQ_N                    registered Z80 bus request
//   RST_N,CPRST_N,NETRST_N     system / coprocessor / network resets
//   SPINDIS_N                  spinner disable
//   IS3_N                      qualified port-3 read select
module adam_mioc (
    input  logic B_PHI,
    input  logic N_CVRST,
    input  logic PBRST_N,
    input  logic BA15,
    input  logic BA14,
    input  logic BA13,
    input  logic BA7,
    input  logic BA6,
    input  logic BD0,
    input  logic BD1,
    input  logic BD2,
    input  logic BD3,
    input  logic N_BWR,
    input  logic BRD_N,
    input  logic BMREQ_N,
    input  logic IORQ_N,
    input  logic BRFSH_N,
    input  logic BM1_N,
    input  logic WAIT_N,
    input  logic BUSAK_N,
    input  logic DMA_N,
    input  logic OS3_N,
    output logic RA7,
    output logic RAS_N,
    output logic CAS1_N,
    output logic CAS2_N,
    output logic MUX,
    output logic BOOTROMCS_N,
    output logic AUXROMCS_N,
    output logic AUXDECODE1_N,
    output logic ADDRBUFEN_N,
    output logic EN245_N,
    output logic BUSRQ_N,
    output logic RST_N,
    output logic CPRST_N,
    output logic NETRST_N,
    output logic SPINDIS_N,
    output logic IS3_N
);

    // Cycle qualifiers
    logic mcyc;
    logic iow;
    logic rdwr;

    // Registered state
    logic [3:0] map_q,   map_d;
    logic [2:0] ctrl_q,  ctrl_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       mux_q,   mux_d;
    logic       busrq_q, busrq_d;
    logic       rfsh_prev_q, rfsh_prev_d;

    // Decoded regions
    logic [1:0] map_lo;
    logic [1:0] map_hi;
    logic       int_lo;
    logic       int_hi;

    assign mcyc   = ~BMREQ_N & BRFSH_N;
    // BM1_N qualifier keeps interrupt-acknowledge cycles from writing registers.
    assign iow    = ~IORQ_N & BM1_N & ~N_BWR;
    assign rdwr   = ~BRD_N | ~N_BWR;
    assign map_lo = map_q[1:0];
    assign map_hi = map_q[3:2];

    always_comb begin
        map_d       = map_q;
        ctrl_d      = ctrl_q;
        mux_d       = mux_q;
        busrq_d     = busrq_q;
        cnt_d       = cnt_q;
        rfsh_prev_d = BRFSH_N;

        // Pushbutton reset takes priority over a simultaneous port write.
        if (!PBRST_N) begin
            map_d  = 4'b0000;
            ctrl_d = 3'b000;
        end else if (iow && !BA7) begin
            if (BA6) begin
                map_d = {BD3, BD2, BD1, BD0};
            end else begin
                ctrl_d = {BD2, BD1, BD0};
            end
        end

        // MUX rises one clock into a memory cycle; refresh cycles leave it alone
        // (BMREQ_N is low then, so it is neither set nor cleared).
        if (mcyc) begin
            mux_d = 1'b1;
        end else if (BMREQ_N) begin
            mux_d = 1'b0;
        end

        // Count completed refresh pulses (rising edge of BRFSH_N).
        if (!rfsh_prev_q && BRFSH_N) begin
            cnt_d = cnt_q + 8'd1;
        end

        // A pending WAIT holds off a new bus request; release is immediate.
        if (DMA_N) begin
            busrq_d = 1'b1;
        end else if (WAIT_N) begin
            busrq_d = 1'b0;
        end
    end

    always_ff @(posedge B_PHI or posedge N_CVRST) begin
        if (N_CVRST) begin
            map_q       <= 4'b0000;
            ctrl_q      <= 3'b000;
            mux_q       <= 1'b0;
            busrq_q     <= 1'b1;
            cnt_q       <= 8'd0;
            // Treat "no previous edge" as refresh inactive so leaving reset
            // never counts a spurious pulse.
            rfsh_prev_q <= 1'b1;
        end else begin
            map_q       <= map_d;
            ctrl_q      <= ctrl_d;
            mux_q       <= mux_d;
            busrq_q     <= busrq_d;
            cnt_q       <= cnt_d;
            rfsh_prev_q <= rfsh_prev_d;
        end
    end

    // Internal DRAM hit in each half. With lo=11 the OS7 ROM only covers
    // 0x0000-0x1FFF; the rest of the lower half is internal RAM.
    assign int_lo = mcyc & ~BA15 &
                    ((map_lo == 2'b01) | ((map_lo == 2'b11) & (BA14 | BA13)));
    assign int_hi = mcyc & BA15 & (map_hi == 2'b00);

    assign BOOTROMCS_N  = ~(mcyc & ~BA15 & (map_lo == 2'b00));
    assign AUXROMCS_N   = ~(mcyc & ~BA15 & (map_lo == 2'b11) & ~BA14 & ~BA13);
    assign AUXDECODE1_N = ~(mcyc & ((~BA15 & (map_lo == 2'b10)) |
                                    (BA15 & (map_hi != 2'b00))));

    assign RAS_N  = BMREQ_N;
    assign MUX    = mux_q;
    assign CAS1_N = ~(mux_q & int_lo & rdwr);
    assign CAS2_N = ~(mux_q & int_hi & rdwr);

    assign RA7 = ~BRFSH_N ? cnt_q[7] : BA7;

    assign BUSRQ_N = busrq_q;

    assign ADDRBUFEN_N = ~BUSAK_N;
    assign EN245_N     = ~(BUSAK_N & (mcyc | (~IORQ_N & BM1_N)));
    assign IS3_N       = OS3_N | BRD_N;

    assign RST_N     = ~(N_CVRST | ~PBRST_N);
    assign NETRST_N  = RST_N & ~ctrl_q[0];
    assign CPRST_N   = RST_N & ~ctrl_q[2];
    assign SPINDIS_N = ~ctrl_q[1];

endmodule

// File: tb/tb_adam_mioc.sv
// Testbench for adam_mioc: directed bring-up sequence followed by randomized
// bus traffic. Expected outputs come from a behavioural model, are queued by
// the stimulus process and checked by an independent monitor.
module tb_adam_mioc;

    typedef struct packed {
        logic       rst;
        logic       pbrst_n;
        logic       ba15;
        logic       ba14;
        logic       ba13;
        logic       ba7;
        logic       ba6;
        logic [3:0] bd;
        logic       bwr_n;
        logic       brd_n;
        logic       bmreq_n;
        logic       iorq_n;
        logic       brfsh_n;
        logic       bm1_n;
        logic       wait_n;
        logic       busak_n;
        logic       dma_n;
        logic       os3_n;
    } in_t;

    localparam int R_NONE = 0;
    localparam int R_BOOT = 1;
    localparam int R_AUX  = 2;
    localparam int R_EXP  = 3;
    localparam int R_INT  = 4;
    localparam int N_RANDOM = 3000;

    logic clk = 1'b0;
    in_t  cur;

    logic ra7, ras_n, cas1_n, cas2_n, mux, bootromcs_n, auxromcs_n, auxdecode1_n;
    logic addrbufen_n, en245_n, busrq_n, rst_n, cprst_n, netrst_n, spindis_n, is3_n;

    // Behavioural model state
    int   m_map;
    int   m_ctrl;
    int   m_refresh_pulses;
    bit   m_mux;
    bit   m_busrq_n;
    bit   m_prev_rfsh_n;

    logic [15:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    string names[16] = '{"RA7", "RAS_N", "CAS1_N", "CAS2_N", "MUX", "BOOTROMCS_N",
                         "AUXROMCS_N", "AUXDECODE1_N", "ADDRBUFEN_N", "EN245_N",
                         "BUSRQ_N", "RST_N", "CPRST_N", "NETRST_N", "SPINDIS_N", "IS3_N"};

    always #5 clk = ~clk;

    adam_mioc dut (
        .B_PHI(clk), .N_CVRST(cur.rst), .PBRST_N(cur.pbrst_n),
        .BA15(cur.ba15), .BA14(cur.ba14), .BA13(cur.ba13), .BA7(cur.ba7), .BA6(cur.ba6),
        .BD0(cur.bd[0]), .BD1(cur.bd[1]), .BD2(cur.bd[2]), .BD3(cur.bd[3]),
        .N_BWR(cur.bwr_n), .BRD_N(cur.brd_n), .BMREQ_N(cur.bmreq_n), .IORQ_N(cur.iorq_n),
        .BRFSH_N(cur.brfsh_n), .BM1_N(cur.bm1_n), .WAIT_N(cur.wait_n),
        .BUSAK_N(cur.busak_n), .DMA_N(cur.dma_n), .OS3_N(cur.os3_n),
        .RA7(ra7), .RAS_N(ras_n), .CAS1_N(cas1_n), .CAS2_N(cas2_n), .MUX(mux),
        .BOOTROMCS_N(bootromcs_n), .AUXROMCS_N(auxromcs_n), .AUXDECODE1_N(auxdecode1_n),
        .ADDRBUFEN_N(addrbufen_n), .EN245_N(en245_n), .BUSRQ_N(busrq_n),
        .RST_N(rst_n), .CPRST_N(cprst_n), .NETRST_N(netrst_n),
        .SPINDIS_N(spindis_n), .IS3_N(is3_n)
    );

    function automatic in_t idle();
        in_t i;
        i = '0;
        i.pbrst_n = 1'b1;
        i.bwr_n = 1'b1; i.brd_n = 1'b1; i.bmreq_n = 1'b1; i.iorq_n = 1'b1;
        i.brfsh_n = 1'b1; i.bm1_n = 1'b1; i.wait_n = 1'b1; i.busak_n = 1'b1;
        i.dma_n = 1'b1; i.os3_n = 1'b1;
        return i;
    endfunction

    function automatic in_t rand_in();
        in_t i;
        i.rst     = ($urandom_range(0, 299) == 0);
        i.pbrst_n = ($urandom_range(0, 59) != 0);
        i.ba15    = 1'($urandom);
        i.ba14    = 1'($urandom);
        i.ba13    = 1'($urandom);
        i.ba7     = 1'($urandom);
        i.ba6     = 1'($urandom);
        i.bd      = 4'($urandom);
        i.bwr_n   = 1'($urandom);
        i.brd_n   = 1'($urandom);
        i.bmreq_n = ($urandom_range(0, 9) < 3);
        i.iorq_n  = 1'($urandom);
        i.brfsh_n = ($urandom_range(0, 9) < 6);
        i.bm1_n   = ($urandom_range(0, 9) < 8);
        i.wait_n  = ($urandom_range(0, 9) < 7);
        i.busak_n = ($urandom_range(0, 9) < 7);
        i.dma_n   = ($urandom_range(0, 9) < 6);
        i.os3_n   = 1'($urandom);
        return i;
    endfunction

    function automatic void model_reset();
        m_map = 0;
        m_ctrl = 0;
        m_refresh_pulses = 0;
        m_mux = 1'b0;
        m_busrq_n = 1'b1;
        m_prev_rfsh_n = 1'b1;
    endfunction

    // State advance for one rising clock edge with inputs i applied.
    function automatic void model_clock(in_t i);
        bit memory_cycle;
        if (i.rst) begin
            model_reset();
            return;
        end
        memory_cycle = !i.bmreq_n && i.brfsh_n;
        if (!i.pbrst_n) begin
            m_map = 0;
            m_ctrl = 0;
        end else if (!i.iorq_n && i.bm1_n && !i.bwr_n && !i.ba7) begin
            if (i.ba6) m_map = int'(i.bd);
            else       m_ctrl = int'(i.bd) % 8;
        end
        if (memory_cycle)   m_mux = 1'b1;
        else if (i.bmreq_n) m_mux = 1'b0;
        if (!m_prev_rfsh_n && i.brfsh_n) m_refresh_pulses = (m_refresh_pulses + 1) % 256;
        m_prev_rfsh_n = i.brfsh_n;
        if (i.dma_n)       m_busrq_n = 1'b1;
        else if (i.wait_n) m_busrq_n = 1'b0;
    endfunction

    function automatic int region(in_t i);
        int lo, hi;
        lo = m_map % 4;
        hi = m_map / 4;
        if (i.bmreq_n || !i.brfsh_n) return R_NONE;
        if (i.ba15) return (hi == 0) ? R_INT : R_EXP;
        case (lo)
            0:       return R_BOOT;
            1:       return R_INT;
            2:       return R_EXP;
            default: return (i.ba14 || i.ba13) ? R_INT : R_AUX;
        endcase
    endfunction

    function automatic logic [15:0] expect_out(in_t i);
        int  r;
        bit  memory_cycle, cas_hit, sys_rst_n;
        logic [15:0] o;
        r = region(i);
        memory_cycle = !i.bmreq_n && i.brfsh_n;
        cas_hit = m_mux && (r == R_INT) && (!i.brd_n || !i.bwr_n);
        sys_rst_n = !i.rst && i.pbrst_n;
        o[15] = !i.brfsh_n ? (m_refresh_pulses >= 128) : i.ba7;
        o[14] = i.bmreq_n;
        o[13] = !(cas_hit && !i.ba15);
        o[12] = !(cas_hit && i.ba15);
        o[11] = m_mux;
        o[10] = (r != R_BOOT);
        o[9]  = (r != R_AUX);
        o[8]  = (r != R_EXP);
        o[7]  = !i.busak_n;
        o[6]  = !(i.busak_n && (memory_cycle || (!i.iorq_n && i.bm1_n)));
        o[5]  = m_busrq_n;
        o[4]  = sys_rst_n;
        o[3]  = sys_rst_n && ((m_ctrl & 4) == 0);
        o[2]  = sys_rst_n && ((m_ctrl & 1) == 0);
        o[1]  = ((m_ctrl & 2) == 0);
        o[0]  = i.os3_n || i.brd_n;
        return o;
    endfunction

    // One bus cycle: clock the model on the edge, then present new inputs and
    // queue the response the monitor must see before the next edge.
    task automatic apply(input in_t nx);
        @(posedge clk);
        model_clock(cur);
        #2;
        cur = nx;
        if (cur.rst) model_reset();
        if (!cur.rst && cur.pbrst_n && !cur.iorq_n && cur.bm1_n && !cur.bwr_n && !cur.ba7)
            $display("t=%0t io write port %s data %h", $time, cur.ba6 ? "0x7F" : "0x3F", cur.bd);
        exp_q.push_back(expect_out(cur));
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        logic [15:0] got, want;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got = {ra7, ras_n, cas1_n, cas2_n, mux, bootromcs_n, auxromcs_n,
                       auxdecode1_n, addrbufen_n, en245_n, busrq_n, rst_n, cprst_n,
                       netrst_n, spindis_n, is3_n};
                for (int b = 0; b < 16; b++) begin
                    checks++;
                    if (got[b] === want[b]) passed++;
                    else $display("FAIL %s t=%0t got %b expected %b", names[15 - b],
                                  $time, got[b], want[b]);
                end
            end
        end
    end

    initial begin
        in_t nx;
        cur = idle();
        cur.rst = 1'b1;
        model_reset();

        // Reset held, then released with the boot ROM selected.
        nx = idle(); nx.rst = 1'b1;
        apply(nx);
        apply(nx);
        nx = idle(); nx.bmreq_n = 1'b0;
        apply(nx);

        // MAP=0001, then read 0x2000 from internal RAM.
        nx = idle(); nx.iorq_n = 1'b0; nx.bwr_n = 1'b0; nx.ba6 = 1'b1; nx.bd = 4'h1;
        apply(nx);
        nx = idle(); nx.bmreq_n = 1'b0; nx.brd_n = 1'b0; nx.ba13 = 1'b1;
        apply(nx);
        apply(nx);
        apply(idle());

        // MAP=0011: OS7 at 0x0000, RAM at 0x2000; then MAP=0100 read 0x8000.
        nx = idle(); nx.iorq_n = 1'b0; nx.bwr_n = 1'b0; nx.ba6 = 1'b1; nx.bd = 4'h3;
        apply(nx);
        nx = idle(); nx.bmreq_n = 1'b0; nx.brd_n = 1'b0;
        apply(nx); apply(nx);
        nx.ba13 = 1'b1;
        apply(nx);
        apply(idle());
        nx = idle(); nx.iorq_n = 1'b0; nx.bwr_n = 1'b0; nx.ba6 = 1'b1; nx.bd = 4'h4;
        apply(nx);
        nx = idle(); nx.bmreq_n = 1'b0; nx.brd_n = 1'b0; nx.ba15 = 1'b1;
        apply(nx); apply(nx);

        // 130 refresh pulses so the counter MSB becomes visible on RA7.
        for (int p = 0; p < 130; p++) begin
            nx = idle(); nx.bmreq_n = 1'b0; nx.brfsh_n = 1'b0; nx.ba7 = 1'($urandom);
            apply(nx);
            nx = idle(); nx.ba7 = 1'($urandom);
            apply(nx);
        end

        // DMA request / acknowledge / release.
        nx = idle(); nx.dma_n = 1'b0;
        apply(nx); apply(nx);
        nx.busak_n = 1'b0; nx.bmreq_n = 1'b0;
        apply(nx);
        apply(idle()); apply(idle());

        // CTRL=101, then pushbutton reset clears it.
        nx = idle(); nx.iorq_n = 1'b0; nx.bwr_n = 1'b0; nx.bd = 4'h5;
        apply(nx);
        apply(idle());
        nx = idle(); nx.pbrst_n = 1'b0;
        apply(nx);
        apply(idle());

        for (int n = 0; n < N_RANDOM; n++) apply(rand_in());

        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
